ex_result_queue: RTL and testbench
==================================

Name: ex_result_queue

Overview:
- Parametrised, elastic successor to the single-entry execute-stage output bundle.
- Buffers up to DEPTH execution results between the execute stage and the memory stage using a valid/ready handshake. Each result carries alu_data, memory_data, overflow, zero, control and compflg.
- First-word-fall-through FIFO with synchronous flush for pipeline squash.
- Sits directly after the ALU in the execution stage and drives the memory-stage inputs and the output monitor.

Parameters:
- XLEN, 32, width of alu_data and memory_data.
- DEPTH, 4, number of entries; minimum 2; any integer, need not be a power of two.
- CTRL_W, 16, width of the packed control field (control_type bits).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents a result.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_alu_data  in  XLEN  ALU result.
- in_memory_data  in  XLEN  store data.
- in_overflow  in  1  ALU overflow flag.
- in_zero  in  1  ALU zero flag.
- in_control  in  CTRL_W  packed control word.
- in_compflg  in  1  compare/branch-taken flag.
- flush  in  1  squash all stored and incoming results.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts head.
- out_alu_data, out_memory_data  out  XLEN  head fields.
- out_overflow, out_zero, out_compflg  out  1  head flags.
- out_control  out  CTRL_W  head control word.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=1 at edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0; all out_* data and flags read 0.
  - Storage contents are not cleared.
  - Reset overrides flush, push and pop in the same cycle.
- Push:
  - Occurs when in_valid && in_ready.
  - Entry is written at wr_ptr; wr_ptr advances.
- Pop:
  - Occurs when out_valid && out_ready; rd_ptr advances.
- Pointer wrap:
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- count update:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
- Ready and full:
  - in_ready is combinational from count only; it never depends on out_ready.
  - When full, no push is accepted even if a pop occurs in the same cycle.
- Latency:
  - A push into an empty queue is visible on out_* with out_valid=1 the next cycle. Minimum latency is 1; there is no combinational in-to-out path.
- Output hold and gating:
  - While out_valid=1 && out_ready=0, out_* stay stable.
  - out_* read 0 whenever out_valid=0.
- Empty:
  - out_valid=0; a pop cannot occur.
- Flush:
  - Takes effect at the next edge: pointers and count go to 0 and out_valid=0.
  - Flush has priority: a push or pop in the same cycle is discarded and not counted.
  - in_ready remains (count < DEPTH) during the flush cycle.
- Input X handling:
  - X on in_* is ignored when in_valid=0.

Optional Feature:
- Macro: EX_RESULT_OVF_STATS_EN.
- When defined:
  - Adds output ovf_cnt (16 bits).
  - ovf_cnt increments on every pop whose out_overflow=1, saturating at 16'hFFFF.
  - Cleared by rst; NOT cleared by flush.
- When undefined:
  - Port and counter are absent.
  - No other behaviour changes.

Decomposition:
- common package adds:
  - EX_XLEN_DEFAULT=32.
  - ex_result_t packed struct (alu_data, memory_data, overflow, zero, control_type control, compflg) for XLEN=32 users.
  - EX_CTRL_W = $bits(control_type).
- Sub-module ex_result_ram:
  - DEPTH x (2*XLEN+CTRL_W+3) register array.
  - Synchronous write port; asynchronous read addressed by rd_ptr.
- Top module holds the pointers, count, flush/handshake logic and the optional counter.

Test Plan:
- Reset then push A (alu=32'h0000_0005, zero=0) with out_ready=0:
  - next cycle out_valid=1, out_alu_data=5, count=1.
  - output held while out_ready=0.
- Push 4 entries with out_ready=0 (DEPTH=4):
  - in_ready=0 after 4th push.
  - a 5th in_valid is ignored; count stays 4.
  - drain yields entries in order 1,2,3,4.
- DEPTH=3 instance, 10 pushes/pops interleaved at a 1-in/1-out rate:
  - pointers wrap 2->0.
  - data order preserved; count never exceeds 3.
- Full queue, in_valid=1 and out_ready=1 in the same cycle:
  - pop occurs, push rejected; count=3.
  - next cycle push accepted; count=4.
- Count=2, flush=1 with in_valid=1 and out_ready=1:
  - next cycle count=0, out_valid=0, out_* = 0.
  - neither the incoming entry nor the popped entry is recorded.
- With EX_RESULT_OVF_STATS_EN:
  - pop 3 entries with overflow=1,0,1 -> ovf_cnt=2.
  - flush -> ovf_cnt still 2.
  - rst -> ovf_cnt=0.

Source files
------------

// File: rtl/ex_result_queue_pkg.sv
// ex_result_queue_pkg: shared types and constants for the execute-stage result queue.
//   control_type  - packed control word carried alongside each result
//   ex_result_t   - one execute-stage result for XLEN=32 users
//   ex_entry_w()  - storage width of one queue entry for a given XLEN/CTRL_W
package ex_result_queue_pkg;

    localparam int EX_XLEN_DEFAULT = 32;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [4:0] rd_addr;
    } control_type;

    localparam int EX_CTRL_W = $bits(control_type);

    typedef struct packed {
        logic [EX_XLEN_DEFAULT-1:0] alu_data;
        logic [EX_XLEN_DEFAULT-1:0] memory_data;
        logic                       overflow;
        logic                       zero;
        control_type                control;
        logic                       compflg;
    } ex_result_t;

    // Two data words, the control word and three single-bit flags.
    function automatic int ex_entry_w(input int xlen, input int ctrl_w);
        return 2 * xlen + ctrl_w + 3;
    endfunction

endpackage

// File: rtl/ex_result_ram.sv
// ex_result_ram: DEPTH x WIDTH register array backing the result queue.
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (asynchronous read)
//   rdata  - read data
// Contents are deliberately not reset; occupancy is tracked by the owner.
module ex_result_ram #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 83,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ex_result_queue.sv
// ex_result_queue: first-word-fall-through elastic buffer between execute and memory stages.
//   clk, rst                - clock, synchronous active-high reset
//   in_valid/in_ready       - execute-stage handshake; in_ready = (count < DEPTH)
//   in_*                    - result fields written on push
//   flush                   - squash stored and incoming results at the next edge
//   out_valid/out_ready     - memory-stage handshake on the head entry
//   out_*                   - head fields, forced to 0 while out_valid = 0
//   count                   - current occupancy
//   ovf_cnt                 - saturating count of popped overflow results
//                             (present only with EX_RESULT_OVF_STATS_EN defined)
module ex_result_queue
    import ex_result_queue_pkg::*;
#(
    parameter int XLEN   = EX_XLEN_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int CTRL_W = EX_CTRL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_alu_data,
    input  logic [XLEN-1:0]            in_memory_data,
    input  logic                       in_overflow,
    input  logic                       in_zero,
    input  logic [CTRL_W-1:0]          in_control,
    input  logic                       in_compflg,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_alu_data,
    output logic [XLEN-1:0]            out_memory_data,
    output logic                       out_overflow,
    output logic                       out_zero,
    output logic                       out_compflg,
    output logic [CTRL_W-1:0]          out_control,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef EX_RESULT_OVF_STATS_EN
    ,
    output logic [15:0]                ovf_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ex_entry_w(XLEN, CTRL_W);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [ENT_W-1:0] wr_entry, rd_entry;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    assign wr_entry = {in_alu_data, in_memory_data, in_overflow, in_zero, in_control, in_compflg};

    ex_result_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENT_W),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign {out_alu_data, out_memory_data, out_overflow, out_zero, out_control, out_compflg} =
        out_valid ? rd_entry : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef EX_RESULT_OVF_STATS_EN
    logic [15:0] ovf_cnt_q;

    // A pop squashed by flush is not a pop; flush itself leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (pop && !flush && out_overflow && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_ex_result_queue.sv
// Bench for ex_result_queue: DEPTH=4 and DEPTH=3 instances, a queue-based reference model,
// a per-cycle compare process and directed scenarios with literal expectations.
module tb_ex_result_queue;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] mem;
        logic        ovf;
        logic        zero;
        logic [15:0] ctrl;
        logic        cmp;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    // DEPTH=4 instance signals
    logic        v4, r4, f4, rdy4, o4v;
    ent_t        d4;
    logic [31:0] o4_alu, o4_mem;
    logic        o4_ovf, o4_zero, o4_cmp;
    logic [15:0] o4_ctrl;
    logic [2:0]  cnt4;
    ent_t        o4;
    assign o4 = {o4_alu, o4_mem, o4_ovf, o4_zero, o4_ctrl, o4_cmp};

    // DEPTH=3 instance signals
    logic        v3, r3, f3, rdy3, o3v;
    ent_t        d3;
    logic [31:0] o3_alu, o3_mem;
    logic        o3_ovf, o3_zero, o3_cmp;
    logic [15:0] o3_ctrl;
    logic [1:0]  cnt3;
    ent_t        o3;
    assign o3 = {o3_alu, o3_mem, o3_ovf, o3_zero, o3_ctrl, o3_cmp};

`ifdef EX_RESULT_OVF_STATS_EN
    logic [15:0] ovf4, ovf3;
`endif

    ex_result_queue #(.XLEN(32), .DEPTH(4), .CTRL_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4),
        .in_alu_data(d4.alu), .in_memory_data(d4.mem), .in_overflow(d4.ovf),
        .in_zero(d4.zero), .in_control(d4.ctrl), .in_compflg(d4.cmp), .flush(f4),
        .out_valid(o4v), .out_ready(r4), .out_alu_data(o4_alu), .out_memory_data(o4_mem),
        .out_overflow(o4_ovf), .out_zero(o4_zero), .out_compflg(o4_cmp),
        .out_control(o4_ctrl), .count(cnt4)
`ifdef EX_RESULT_OVF_STATS_EN
        , .ovf_cnt(ovf4)
`endif
    );

    ex_result_queue #(.XLEN(32), .DEPTH(3), .CTRL_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
        .in_alu_data(d3.alu), .in_memory_data(d3.mem), .in_overflow(d3.ovf),
        .in_zero(d3.zero), .in_control(d3.ctrl), .in_compflg(d3.cmp), .flush(f3),
        .out_valid(o3v), .out_ready(r3), .out_alu_data(o3_alu), .out_memory_data(o3_mem),
        .out_overflow(o3_ovf), .out_zero(o3_zero), .out_compflg(o3_cmp),
        .out_control(o3_ctrl), .count(cnt3)
`ifdef EX_RESULT_OVF_STATS_EN
        , .ovf_cnt(ovf3)
`endif
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ent_t mk(input logic [31:0] a, input logic o);
        ent_t e;
        e      = '0;
        e.alu  = a;
        e.mem  = ~a;
        e.ovf  = o;
        e.zero = (a == 32'd0);
        e.ctrl = a[15:0] ^ 16'h5a5a;
        e.cmp  = a[1];
        return e;
    endfunction

    // Reference model: an ordered list of held results per instance.
    ent_t        q4[$];
    ent_t        q3[$];
    logic [15:0] om4 = '0;
    logic [15:0] om3 = '0;
    bit          pp4, ps4, pp3, ps3;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            q4.delete();
            q3.delete();
            om4 = '0;
            om3 = '0;
        end else begin
            if (f4) begin
                q4.delete();
            end else begin
                pp4 = (q4.size() != 0) && r4;
                ps4 = v4 && (q4.size() < 4);
                if (pp4) begin
                    if (q4[0].ovf && om4 != 16'hFFFF) om4 = om4 + 16'd1;
                    void'(q4.pop_front());
                end
                if (ps4) q4.push_back(d4);
            end
            if (f3) begin
                q3.delete();
            end else begin
                pp3 = (q3.size() != 0) && r3;
                ps3 = v3 && (q3.size() < 3);
                if (pp3) begin
                    if (q3[0].ovf && om3 != 16'hFFFF) om3 = om3 + 16'd1;
                    void'(q3.pop_front());
                end
                if (ps3) q3.push_back(d3);
            end
        end
    end

    // Compare process: outputs against the model every cycle, on the falling edge.
    ent_t e4, e3;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e4 = (q4.size() != 0) ? q4[0] : '0;
            e3 = (q3.size() != 0) ? q3[0] : '0;
            check("d4_valid", o4v, q4.size() != 0);
            check("d4_head",  o4,  e4);
            check("d4_count", cnt4, q4.size());
            check("d4_ready", rdy4, q4.size() < 4);
            check("d3_valid", o3v, q3.size() != 0);
            check("d3_head",  o3,  e3);
            check("d3_count", cnt3, q3.size());
            check("d3_ready", rdy3, q3.size() < 3);
`ifdef EX_RESULT_OVF_STATS_EN
            check("d4_ovf_cnt", ovf4, om4);
            check("d3_ovf_cnt", ovf3, om3);
`endif
        end
    end

    initial begin
        rst = 1'b1;
        v4 = 1'b0; r4 = 1'b0; f4 = 1'b0; d4 = '0;
        v3 = 1'b0; r3 = 1'b0; f3 = 1'b0; d3 = '0;
        tick();
        chk_en = 1'b1;
        check("rst_valid", o4v, 1'b0);
        check("rst_count", cnt4, 3'd0);
        check("rst_head",  o4, 83'd0);
        tick();
        rst = 1'b0;

        // Single push, one-cycle latency, hold while stalled
        d4 = mk(32'h0000_0005, 1'b0);
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        d4 = 'x;
        check("t1_valid", o4v, 1'b1);
        check("t1_alu",   o4_alu, 32'd5);
        check("t1_count", cnt4, 3'd1);
        tick();
        tick();
        check("t1_hold", o4_alu, 32'd5);
        r4 = 1'b1;
        tick();
        r4 = 1'b0;
        check("t1_empty", cnt4, 3'd0);

        // Fill to DEPTH, overflow push ignored, drain in order
        for (int k = 1; k <= 4; k++) begin
            d4 = mk(k, 1'b0);
            v4 = 1'b1;
            tick();
        end
        check("t2_full_ready", rdy4, 1'b0);
        check("t2_full_count", cnt4, 3'd4);
        d4 = mk(32'd5, 1'b0);
        tick();
        v4 = 1'b0;
        check("t2_ignored_count", cnt4, 3'd4);
        r4 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t2_order", o4_alu, k);
            tick();
        end
        r4 = 1'b0;
        check("t2_drained", cnt4, 3'd0);

        // Full with simultaneous push and pop: push rejected, accepted next cycle
        for (int k = 1; k <= 4; k++) begin
            d4 = mk(32'h10 + k, 1'b0);
            v4 = 1'b1;
            tick();
        end
        d4 = mk(32'h15, 1'b0);
        r4 = 1'b1;
        tick();
        r4 = 1'b0;
        check("t4_pop_only", cnt4, 3'd3);
        check("t4_head", o4_alu, 32'h12);
        tick();
        v4 = 1'b0;
        check("t4_push_next", cnt4, 3'd4);

        // Flush at count=2 with push and pop in the same cycle
        r4 = 1'b1;
        tick();
        tick();
        r4 = 1'b0;
        check("t5_pre_count", cnt4, 3'd2);
        d4 = mk(32'h99, 1'b0);
        v4 = 1'b1;
        r4 = 1'b1;
        f4 = 1'b1;
        tick();
        f4 = 1'b0;
        v4 = 1'b0;
        r4 = 1'b0;
        check("t5_count", cnt4, 3'd0);
        check("t5_valid", o4v, 1'b0);
        check("t5_head",  o4, 83'd0);
        tick();
        check("t5_nothing_kept", cnt4, 3'd0);

        // Overflow statistics: pop overflow=1,0,1
        for (int k = 0; k < 3; k++) begin
            d4 = mk(32'h40 + k, (k != 1));
            v4 = 1'b1;
            tick();
        end
        v4 = 1'b0;
        r4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t6_ovf_flag", o4_ovf, (k != 1));
            tick();
        end
        r4 = 1'b0;
`ifdef EX_RESULT_OVF_STATS_EN
        check("t6_ovf_cnt", ovf4, 16'd2);
`endif
        d4 = mk(32'h50, 1'b1);
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        f4 = 1'b1;
        r4 = 1'b1;
        tick();
        f4 = 1'b0;
        r4 = 1'b0;
        check("t6_flush_count", cnt4, 3'd0);
`ifdef EX_RESULT_OVF_STATS_EN
        check("t6_ovf_after_flush", ovf4, 16'd2);
`endif

        // DEPTH=3: interleaved push/pop across several pointer wraps
        d3 = mk(32'd100, 1'b0);
        v3 = 1'b1;
        tick();
        d3 = mk(32'd101, 1'b0);
        tick();
        check("t3_prefill", cnt3, 2'd2);
        r3 = 1'b1;
        for (int k = 2; k < 12; k++) begin
            d3 = mk(32'd100 + k, k[0]);
            check("t3_order", o3_alu, 32'd100 + k - 2);
            check("t3_count", cnt3, 2'd2);
            tick();
        end
        v3 = 1'b0;
        check("t3_tail0", o3_alu, 32'd110);
        tick();
        check("t3_tail1", o3_alu, 32'd111);
        tick();
        r3 = 1'b0;
        check("t3_drained", cnt3, 2'd0);

        // Reset with data held and the stats counter non-zero
        d4 = mk(32'h77, 1'b1);
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        rst = 1'b1;
        r4 = 1'b1;
        tick();
        rst = 1'b0;
        r4 = 1'b0;
        check("t7_rst_count", cnt4, 3'd0);
        check("t7_rst_head",  o4, 83'd0);
`ifdef EX_RESULT_OVF_STATS_EN
        check("t7_rst_ovf", ovf4, 16'd0);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
